kyber_rej_uniform: RTL and testbench

- Rejection sampler for Kyber matrix generation; sits directly downstream of the keccak core running in SHAKE128 mode.
- Consumes the squeezed byte stream as 64-bit words and parses 3-byte groups into two 12-bit candidates.
- Emits only candidates < Q as polynomial coefficients, indexed 0..N-1, then signals done.
- An integration FIFO between keccak and this block absorbs backpressure, because keccak has no output stall.

---
 rtl/kyber_rej_uniform.sv | 197 +++++++++++++++++++
 tb/tb_kyber_rej_uniform.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kyber_rej_uniform.sv
// Purpose: Kyber rejection sampler. Parses a SHAKE128 byte stream into 12-bit
//          candidates and emits those below Q as indexed coefficients 0..N-1.
// Latency: one cycle from the parse/pending decision to o_coef_valid.
// Backpressure: input ready drops while more than one word is buffered; the
//               coefficient output has no backpressure.
// Ports: i_clk/i_rstn clock and async active-low reset; i_start starts one
//        polynomial (idle only); i_bytes/i_bytes_valid/o_bytes_ready input
//        word handshake (MSB byte first); o_coef/o_coef_idx/o_coef_valid
//        coefficient strobe; o_done one-cycle end pulse; o_busy high while running.
module kyber_rej_uniform #(
  parameter int BW_DATA = 64,
  parameter int Q       = 3329,
  parameter int N       = 256,
  parameter int BW_COEF = 12
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  input  logic [BW_DATA-1:0] i_bytes,
  input  logic               i_bytes_valid,
  output logic               o_bytes_ready,
  output logic [BW_COEF-1:0] o_coef,
  output logic [7:0]         o_coef_idx,
  output logic               o_coef_valid,
  output logic               o_done,
  output logic               o_busy
);

  localparam int NB   = BW_DATA / 8;
  localparam int NBUF = 2 * NB;
  localparam int CW   = $clog2(NBUF + 1);
  localparam logic [CW-1:0]      NBV  = CW'(NB);
  localparam logic [CW-1:0]      GRP  = CW'(3);
  localparam logic [BW_COEF-1:0] QV   = BW_COEF'(Q);
  localparam logic [7:0]         LAST = 8'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q;
  logic   done_q, busy_q;

  // Byte 0 of the shift buffer is the head of the stream.
  logic [7:0]         buf_q [NBUF];
  logic [7:0]         buf_d [NBUF];
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic [BW_COEF-1:0] pend_coef_q, pend_coef_d;
  logic [7:0]         coef_cnt_q, coef_cnt_d;
  logic [BW_COEF-1:0] coef_q;
  logic [7:0]         coef_idx_q;
  logic               coef_vld_q;

  logic               emit_d;
  logic [BW_COEF-1:0] coef_d;
  logic               load, parse, end_run;
  logic [CW-1:0]      base;
  logic [BW_COEF-1:0] d1, d2;

  assign o_bytes_ready = (state_q != S_RUN) || (cnt_q <= NBV);
  assign o_coef        = coef_q;
  assign o_coef_idx    = coef_idx_q;
  assign o_coef_valid  = coef_vld_q;
  assign o_done        = done_q;
  assign o_busy        = busy_q;

  assign d1 = {buf_q[1][3:0], buf_q[0]};
  assign d2 = {buf_q[2], buf_q[1][7:4]};

  // The last strobe is on the output; the run leaves S_RUN at the next edge.
  assign end_run = (state_q == S_RUN) && coef_vld_q && (coef_idx_q == LAST);

  always_comb begin
    buf_d       = buf_q;
    pend_d      = pend_q;
    pend_coef_d = pend_coef_q;
    coef_cnt_d  = coef_cnt_q;
    emit_d      = 1'b0;
    coef_d      = '0;
    load        = 1'b0;
    parse       = 1'b0;
    base        = '0;

    case (state_q)
      S_IDLE: begin
        pend_d     = 1'b0;
        coef_cnt_d = '0;
        // The word presented alongside i_start is the first word of the run.
        load       = i_start && i_bytes_valid;
      end
      S_RUN: begin
        load = i_bytes_valid && o_bytes_ready;
        if (pend_q) begin
          pend_d = 1'b0;
          if (pend_coef_q < QV) begin
            emit_d = 1'b1;
            coef_d = pend_coef_q;
          end
        end else if (cnt_q >= GRP) begin
          parse       = 1'b1;
          pend_d      = 1'b1;
          pend_coef_d = d2;
          if (d1 < QV) begin
            emit_d = 1'b1;
            coef_d = d1;
          end
        end
        base = parse ? (cnt_q - GRP) : cnt_q;
      end
      default: begin
        pend_d = 1'b0;
      end
    endcase

    if (parse) begin
      for (int i = 0; i < NBUF - 3; i++) buf_d[i] = buf_q[i + 3];
      for (int i = NBUF - 3; i < NBUF; i++) buf_d[i] = 8'h00;
    end

    // New word lands right behind the bytes that survive this cycle's parse.
    for (int i = 0; i < NBUF; i++) begin
      for (int k = 0; k < NB; k++) begin
        if (load && (i == int'(base) + k)) buf_d[i] = i_bytes[BW_DATA-1-8*k -: 8];
      end
    end

    cnt_d = base + (load ? NBV : '0);

    if (emit_d) begin
      coef_cnt_d = coef_cnt_q + 8'd1;
      // Final coefficient decided: drop the buffered stream and the pending d2.
      if (coef_cnt_q == LAST) begin
        cnt_d  = '0;
        pend_d = 1'b0;
      end
    end

    if (end_run) cnt_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < NBUF; i++) buf_q[i] <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_coef_q <= '0;
      coef_cnt_q  <= '0;
      coef_q      <= '0;
      coef_idx_q  <= '0;
      coef_vld_q  <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_coef_q <= pend_coef_d;
      coef_cnt_q  <= coef_cnt_d;
      coef_vld_q  <= emit_d;
      if (emit_d) begin
        coef_q     <= coef_d;
        coef_idx_q <= coef_cnt_q;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (end_run) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kyber_rej_uniform.sv
// Purpose: self-checking bench for kyber_rej_uniform (table vectors, full runs,
//          mid-run reset) with a byte-stream reference model and scoreboard.
// Latency: strobes compared at the falling edge after they appear.
// Backpressure: the word driver holds each word valid until ready is seen.
module tb_kyber_rej_uniform;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_start = 1'b0;
  logic [63:0] i_bytes = '0;
  logic        i_bytes_valid = 1'b0;
  logic        o_bytes_ready;
  logic [11:0] o_coef;
  logic [7:0]  o_coef_idx;
  logic        o_coef_valid;
  logic        o_done;
  logic        o_busy;

  kyber_rej_uniform dut (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_start       (i_start),
    .i_bytes       (i_bytes),
    .i_bytes_valid (i_bytes_valid),
    .o_bytes_ready (o_bytes_ready),
    .o_coef        (o_coef),
    .o_coef_idx    (o_coef_idx),
    .o_coef_valid  (o_coef_valid),
    .o_done        (o_done),
    .o_busy        (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int coef;
    int idx;
  } exp_t;

  typedef struct {
    logic [63:0] w0;
    logic [63:0] w1;
    int          n_exp;
    int          e0;
    int          e1;
    int          gap;
    string       name;
  } vec_t;

  exp_t       sbq[$];
  logic [7:0] mq[$];
  int         m_idx = 0;
  int         obs_coef[$];
  int         obs_cyc[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         run_strobes = 0;
  int         done_cnt = 0;
  int         last255 = -100;

  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endfunction

  // Reference parse of the squeezed stream; only complete 3-byte groups count.
  function automatic void model_push(input logic [63:0] w);
    logic [7:0] b0, b1, b2;
    int c1, c2;
    for (int k = 0; k < 8; k++) mq.push_back(w[63-8*k -: 8]);
    while (mq.size() >= 3 && m_idx < 256) begin
      b0 = mq.pop_front();
      b1 = mq.pop_front();
      b2 = mq.pop_front();
      c1 = int'({b1[3:0], b0});
      c2 = int'({b2, b1[7:4]});
      if (c1 < 3329) begin
        sbq.push_back('{c1, m_idx});
        m_idx++;
      end
      if (m_idx < 256 && c2 < 3329) begin
        sbq.push_back('{c2, m_idx});
        m_idx++;
      end
    end
  endfunction

  always @(negedge i_clk) begin
    exp_t e;
    if (o_coef_valid) begin
      obs_coef.push_back(int'(o_coef));
      obs_cyc.push_back(cyc);
      run_strobes++;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got coef %0d idx %0d, required no strobe",
                 o_coef, o_coef_idx);
      end else begin
        e = sbq.pop_front();
        check("coef", int'(o_coef), e.coef);
        check("coef_idx", int'(o_coef_idx), e.idx);
      end
      if (o_coef_idx == 8'd255) last255 = cyc;
    end
    if (o_done) begin
      done_cnt++;
      check("done_after_last", cyc - last255, 1);
    end
  end

  task automatic do_reset();
    i_start = 1'b0;
    i_bytes_valid = 1'b0;
    @(negedge i_clk);
    #2 i_rstn = 1'b0;
    #1;
    check("rst_coef", int'(o_coef), 0);
    check("rst_idx", int'(o_coef_idx), 0);
    check("rst_valid", int'(o_coef_valid), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_ready", int'(o_bytes_ready), 1);
    @(negedge i_clk);
    sbq.delete();
    mq.delete();
    m_idx = 0;
    obs_coef.delete();
    obs_cyc.delete();
    run_strobes = 0;
    done_cnt = 0;
    last255 = -100;
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_word(input logic [63:0] w);
    i_bytes = w;
    i_bytes_valid = 1'b1;
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_bytes_valid = 1'b0;
    model_push(w);
  endtask

  // Called #1 after a rising edge; ready is settled for the next edge.
  task automatic send_word(input logic [63:0] w, output bit ok);
    i_bytes = w;
    i_bytes_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 64 && !ok; c++) begin
      if (o_bytes_ready) ok = 1'b1;
      @(posedge i_clk);
      #1;
    end
    if (ok) model_push(w);
  endtask

  task automatic full_run(input int stop_at, input bit drain_all);
    logic [63:0] w;
    bit ok;
    w = {$urandom, $urandom};
    start_word(w);
    check("busy_in_run", int'(o_busy), 1);
    for (int k = 1; k < 84; k++) begin
      if (stop_at > 0 && run_strobes >= stop_at) break;
      if (!drain_all && m_idx >= 256) break;
      w = {$urandom, $urandom};
      send_word(w, ok);
      check("word_accept", int'(ok), 1);
      if (!ok) break;
    end
    i_bytes_valid = 1'b0;
  endtask

  task automatic wait_done(input bit poke);
    bit seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge i_clk);
      #1;
      if (done_cnt > 0) begin
        seen = 1'b1;
        // Start requests during the done cycle must be ignored.
        if (poke && o_done) i_start = 1'b1;
      end
    end
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    check("done_seen", int'(seen), 1);
    repeat (4) @(posedge i_clk);
    #1;
    check("run_strobes", run_strobes, 256);
    check("sb_empty", sbq.size(), 0);
    check("done_pulses", done_cnt, 1);
    check("idle_busy", int'(o_busy), 0);
    check("idle_done", int'(o_done), 0);
    check("idle_ready", int'(o_bytes_ready), 1);
  endtask

  function automatic vec_t mk(input logic [63:0] w0, input logic [63:0] w1, input int n,
                              input int e0, input int e1, input int gap, input string nm);
    vec_t v;
    v.w0 = w0;
    v.w1 = w1;
    v.n_exp = n;
    v.e0 = e0;
    v.e1 = e1;
    v.gap = gap;
    v.name = nm;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[4];
    bit ok;
    vt[0] = mk(64'h012345FFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 2, 769, 1106, 1, "plain");
    vt[1] = mk(64'hFFFFFF012345FFFF, 64'hFFFFFFFFFFFFFFFF, 2, 769, 1106, 1, "reject_fff");
    vt[2] = mk(64'h001DD0012345FFFF, 64'hFFFFFFFFFFFFFFFF, 3, 3328, 769, 2, "q_boundary");
    vt[3] = mk(64'hFFFFFFFFFFFF0123, 64'h45FFFFFFFFFFFFFF, 2, 769, 1106, 1, "split_word");

    do_reset();

    for (int v = 0; v < 4; v++) begin
      do_reset();
      start_word(vt[v].w0);
      send_word(vt[v].w1, ok);
      check({vt[v].name, "_w1_accept"}, int'(ok), 1);
      i_bytes_valid = 1'b0;
      repeat (30) @(posedge i_clk);
      #1;
      check({vt[v].name, "_count"}, run_strobes, vt[v].n_exp);
      check({vt[v].name, "_sb_empty"}, sbq.size(), 0);
      if (obs_coef.size() >= 2) begin
        check({vt[v].name, "_first"}, obs_coef[0], vt[v].e0);
        check({vt[v].name, "_second"}, obs_coef[1], vt[v].e1);
        check({vt[v].name, "_gap"}, obs_cyc[1] - obs_cyc[0], vt[v].gap);
      end
    end

    // Continuous stream, leftover words drained after the run ends.
    do_reset();
    full_run(0, 1'b1);
    wait_done(1'b0);

    // Abort a run mid-way, then a clean run must restart at index 0.
    do_reset();
    full_run(100, 1'b1);
    check("reached_100", int'(run_strobes >= 100), 1);
    do_reset();
    full_run(0, 1'b0);
    wait_done(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
